// File: rtl/div_if.sv
// Handshake and data bundle between the execute stage and the divider.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    // Requester side (execute stage).
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Iterative 32-bit restoring divider, signed or unsigned.
// One load edge, 32 shift/subtract edges, one finalize edge; result is held
// until the requester drops start_i.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        sgn_q, sgn_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] mag1, mag2;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    // Operand magnitudes and the trial subtraction of the current step.
    always_comb begin
        mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
        diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
        quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~dividend_q[31:0] + 32'd1) : dividend_q[31:0];
        rem_fix = (sgn_q && neg1_q) ? (~dividend_q[64:33] + 32'd1) : dividend_q[64:33];
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sgn_d      = sgn_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (bus.start_i && !bus.annul_i) begin
                    sgn_d     = bus.signed_div_i;
                    neg1_d    = bus.opdata1_i[31];
                    neg2_d    = bus.opdata2_i[31];
                    divisor_d = mag2;
                    cnt_d     = 6'd0;
                    if (bus.opdata2_i == 32'h0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        dividend_d = {32'b0, mag1, 1'b0};
                    end
                end
            end
            BYZERO: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = 64'h0;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) begin
                        dividend_d = {dividend_q[63:0], 1'b0};
                    end else begin
                        dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = END;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            END: begin
                // annul_i is deliberately ignored here: the result already exists.
                if (!bus.start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end
            default: begin
                state_d  = FREE;
                ready_d  = 1'b0;
                result_d = 64'h0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            dividend_q <= 65'h0;
            divisor_q  <= 32'h0;
            sgn_q      <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            result_q   <= 64'h0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sgn_q      <= sgn_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// Randomized scoreboard bench for the iterative divider.
module tb_div;
    logic clk;
    logic rst;
    div_if bus();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;

    logic [63:0] exp_res_q[$];
    int          exp_acc_q[$];
    int          exp_lat_q[$];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference: plain language-level division, zero divisor yields zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        logic [63:0] qq, rr;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qq = q;
            rr = r;
            return {rr[31:0], qq[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: pop on each rising ready_o, check value and latency; check hold while high.
    logic        ready_prev = 1'b0;
    logic [63:0] held_res   = 64'h0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ready_o && !ready_prev) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result %h with no request pending", bus.result_o);
                end else begin
                    logic [63:0] er;
                    int ea, el;
                    er = exp_res_q.pop_front();
                    ea = exp_acc_q.pop_front();
                    el = exp_lat_q.pop_front();
                    check("result", bus.result_o, er);
                    check("latency", 64'(cycle_cnt - ea), 64'(el));
                    $display("txn: result=%h latency=%0d", bus.result_o, cycle_cnt - ea);
                end
                held_res = bus.result_o;
            end else if (bus.ready_o && ready_prev) begin
                check("hold", bus.result_o, held_res);
            end
        end
        ready_prev = bus.ready_o;
    end

    // Present an operation; acceptance happens on the next rising edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        exp_res_q.push_back(ref_div(sgn, a, b));
        exp_acc_q.push_back(cycle_cnt + 1);
        exp_lat_q.push_back((b == 32'h0) ? 1 : 33);
    endtask

    // Wait for ready (bounded), hold start a while, then release and check clear.
    task automatic finish(input int hold, input bit toggle);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1'b1;
            else if (toggle) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = $urandom_range(0, 1);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout: ready_o got 0 required 1 within 40 cycles");
        end
        for (int i = 0; i < hold; i++) begin
            bus.annul_i = $urandom_range(0, 1);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
        check("release_ready", 64'(bus.ready_o), 64'h0);
        check("release_result", bus.result_o, 64'h0);
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit toggle);
        issue(sgn, a, b);
        finish($urandom_range(0, 3), toggle);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(bus.ready_o), 64'h0);
        check("reset_result", bus.result_o, 64'h0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with known answers.
        issue(1'b0, 32'd100, 32'd7);
        check("ref_100_7", exp_res_q[$], 64'h00000002_0000000E);
        finish(2, 1'b0);
        issue(1'b1, 32'hFFFFFFF9, 32'h2);
        check("ref_m7_2_s", exp_res_q[$], 64'hFFFFFFFF_FFFFFFFD);
        finish(1, 1'b0);
        issue(1'b0, 32'hFFFFFFF9, 32'h2);
        check("ref_m7_2_u", exp_res_q[$], 64'h00000001_7FFFFFFC);
        finish(1, 1'b0);
        run(1'b0, 32'd1234, 32'h0, 1'b0);
        run(1'b1, 32'h80000000, 32'h0, 1'b1);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        check("ref_ovf", exp_res_q[$], 64'h00000000_80000000);
        finish(2, 1'b1);
        run(1'b0, 32'hFFFFFFFF, 32'h1, 1'b1);
        run(1'b0, 32'h5, 32'hFFFFFFFF, 1'b0);

        // Annul mid-operation, then a fresh request.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd999;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        repeat (2) begin
            check("annul_ready", 64'(bus.ready_o), 64'h0);
            @(negedge clk);
        end
        run(1'b1, 32'hFFFF0000, 32'd77, 1'b1);

        // Annul while the zero-divisor path is pending.
        @(negedge clk);
        bus.opdata2_i = 32'h0;
        bus.start_i   = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        check("annul_byzero_ready", 64'(bus.ready_o), 64'h0);

        // Reset mid-operation with start held: restart on new operands.
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'd5000;
        bus.opdata2_i    = 32'd9;
        bus.start_i      = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        bus.opdata1_i = 32'hFFFFFC18;
        bus.opdata2_i = 32'd13;
        @(negedge clk);
        check("midrst_ready", 64'(bus.ready_o), 64'h0);
        check("midrst_result", bus.result_o, 64'h0);
        rst = 1'b0;
        exp_res_q.push_back(ref_div(1'b1, 32'hFFFFFC18, 32'd13));
        exp_acc_q.push_back(cycle_cnt + 1);
        exp_lat_q.push_back(33);
        finish(1, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            logic s;
            a = $urandom;
            b = $urandom;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: ;
            endcase
            run(s, a, b, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding results expected 0", exp_res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters: operand width is fixed at 32 bits and result width at 64 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only when a start is accepted.
REQ-005 opdata1_i  input  32  Dividend; sampled only when a start is accepted.
REQ-006 opdata2_i  input  32  Divisor; sampled only when a start is accepted.
REQ-007 start_i  input  1  Division request from the execute stage; held high until the result is consumed.
REQ-008 annul_i  input  1  Abort the operation in progress (pipeline flush or branch cancel).
REQ-009 result_o  output  64  Registered result {remainder[63:32], quotient[31:0]}.
REQ-010 ready_o  output  1  Registered; high while result_o is valid.

Function
REQ-011 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-012 FREE: start_i=1 and annul_i=0 at edge N SHALL start an operation and capture all operands.
  - divisor==0 -> go to BYZERO;
  - otherwise -> go to ON, load dividend register = {32'b0, |op1|, 1'b0} (65 bits), cnt=0.
REQ-013 In FREE, start_i=0 or annul_i=1 SHALL hold the state with ready_o=0 and result_o=0.
REQ-014 Operand magnitude: when signed_div_i=1 and bit31=1 the operand SHALL be replaced by its two's complement; otherwise it passes unchanged.
REQ-015 ON, cnt<32, annul_i=0: each edge SHALL perform one restoring step, then cnt+1.
  - diff = {1'b0, dividend[63:32]} - {1'b0, |divisor|} (33 bits);
  - diff[32]=1 -> dividend = {dividend[63:0], 1'b0};
  - else -> dividend = {diff[31:0], dividend[31:0], 1'b1}.
REQ-016 ON, cnt==32 SHALL finalize: q = dividend[31:0], r = dividend[64:33], then go to END with cnt=0.
  - Signed only: negate q when op1[31]^op2[31]; negate r when op1[31]=1.
  - ready_o=1 and result_o={r,q} registered on this same edge.
REQ-017 Latency: start accepted at edge N SHALL give ready_o=1 from edge N+33 (1 load edge + 32 steps), independent of operand values.
REQ-018 BYZERO SHALL go to END on the next edge with result_o=64'h0 and ready_o=1, i.e. ready_o from edge N+1.
REQ-019 END SHALL hold result_o and ready_o stable while start_i=1; on the edge where start_i is sampled 0 it SHALL go to FREE with ready_o=0 and result_o=0.
REQ-020 annul_i=1 in ON or BYZERO SHALL go to FREE on that edge, with ready_o=0, result_o unchanged at 0, and no result produced.
REQ-021 annul_i in END SHALL have no effect; only start_i=0 leaves END.
REQ-022 Operand input changes after acceptance SHALL NOT affect the result.
REQ-023 Signed overflow (0x80000000 / -1) SHALL NOT be trapped: q=0x80000000, r=0.
REQ-024 Unsigned mode SHALL never negate operands or results.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL enter FREE with cnt=0, dividend=0, ready_o=0 and result_o=64'h0; this overrides start_i and annul_i.
REQ-026 Reset asserted mid-operation (ON/END/BYZERO) SHALL abandon the operation with no result output.
REQ-027 After rst deasserts, a start_i held high SHALL be accepted at the first non-reset edge.

Verification
REQ-028 Unsigned 100/7, start at edge N -> ready_o rises at N+33, result_o=64'h00000002_0000000E; start_i low -> ready_o=0 next edge.
REQ-029 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; unsigned same operands -> 64'h00000001_7FFFFFFC.
REQ-030 Divisor 0 with start -> ready_o=1 at N+1, result_o=64'h0.
REQ-031 annul_i pulsed at N+10 -> FREE, ready_o stays 0; a new start 2 cycles later gives a correct result 33 edges after its acceptance.
REQ-032 rst at N+20, then start held -> operation restarts with new operands; no stale result appears.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000; operands toggled during ON do not change the result.
